// File: rtl/adder_pkg.sv
// adder_pkg: shared types and elaboration helpers for the pipelined adder.
//   add_op_e  : operation select (OP_ADD / OP_SUB)
//   slice_wd  : per-stage slice width for a given operand width / depth
//   cfg_ok    : legal DATA_WD / STAGES combination
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;

  function automatic int slice_wd(input int data_wd, input int stages);
    return data_wd / stages;
  endfunction

  // Depth must be at least one, no deeper than one bit per stage, and divide
  // the operand width evenly so every slice is the same size.
  function automatic bit cfg_ok(input int data_wd, input int stages);
    return (stages >= 1) && (stages <= data_wd) && ((data_wd % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple slice.
//   a, b : slice operands
//   ci   : carry in from the previous slice (or the op bit for slice 0)
//   s    : slice sum
//   co   : carry out to the next stage's carry register
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: STAGES-deep pipelined add/subtract with valid/ready handshake.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid / o_ready : upstream handshake, beat accepted on i_valid && o_ready
//   i_op              : OP_ADD or OP_SUB
//   i_a, i_b          : DATA_WD-bit unsigned operands
//   o_valid / i_ready : downstream handshake, result moves on o_valid && i_ready
//   o_sum             : DATA_WD+1-bit result (carry-out, or borrow for SUB)
// Stage k adds operand slice k plus the carry registered by stage k-1, so a
// result leaves the last stage STAGES cycles after it was accepted.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int DATA_WD = 16,
  parameter int STAGES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  add_op_e            i_op,
  input  logic [DATA_WD-1:0] i_a,
  input  logic [DATA_WD-1:0] i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_WD:0]   o_sum
);

  localparam int SW = slice_wd(DATA_WD, STAGES);

  if (!cfg_ok(DATA_WD, STAGES)) begin : g_bad_cfg
    $error("adder_pipe: DATA_WD must be a multiple of STAGES, 1 <= STAGES <= DATA_WD");
  end

  // Stage k state lives at index k; vld_pipe[k+1] is stage k's valid bit.
  logic [STAGES:1]                vld_pipe;
  logic [STAGES-1:0][DATA_WD-1:0] sum_q, sum_d;
  logic [STAGES-1:0]              cy_q, cy_d;
  logic [STAGES-1:0]              op_q, op_d;
  logic                           stall;

  // Single global stall: the whole pipe freezes while the output is blocked,
  // bubbles included.
  assign stall   = o_valid && !i_ready;
  assign o_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int RW = DATA_WD - LO;  // operand bits not yet consumed
    localparam logic [DATA_WD-1:0] MASK = DATA_WD'({SW{1'b1}}) << LO;

    logic [RW-1:0]      opa, opb;
    logic               ci, op;
    logic [DATA_WD-1:0] psum;
    logic [SW-1:0]      s;
    logic               co;

    if (k == 0) begin : g_in
      // Subtract as a + ~b + 1: invert B and use the op bit as carry-in.
      assign opa  = i_a;
      assign opb  = i_b ^ {DATA_WD{i_op == OP_SUB}};
      assign ci   = (i_op == OP_SUB);
      assign op   = (i_op == OP_SUB);
      assign psum = '0;
    end else begin : g_mid
      assign opa  = g_stage[k-1].g_fwd.a_q;
      assign opb  = g_stage[k-1].g_fwd.b_q;
      assign ci   = cy_q[k-1];
      assign op   = op_q[k-1];
      assign psum = sum_q[k-1];
    end

    adder_slice #(.W(SW)) u_slice (
      .a  (opa[SW-1:0]),
      .b  (opb[SW-1:0]),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    assign sum_d[k] = (psum & ~MASK) | (DATA_WD'(s) << LO);
    assign cy_d[k]  = co;
    assign op_d[k]  = op;

    // Only the upper, still-unused operand slices move on to the next stage.
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SW-1:0] a_q, b_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= opa[RW-1:SW];
          b_q <= opb[RW-1:SW];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      sum_q    <= '0;
      cy_q     <= '0;
      op_q     <= '0;
    end else if (!stall) begin
      // Not stalled means o_ready is high, so i_valid alone marks an accept.
      vld_pipe[1] <= i_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      sum_q <= sum_d;
      cy_q  <= cy_d;
      op_q  <= op_d;
    end
  end

  // For SUB the final carry is "no borrow"; invert it to report the borrow.
  assign o_valid = vld_pipe[STAGES];
  assign o_sum   = {cy_q[STAGES-1] ^ op_q[STAGES-1], sum_q[STAGES-1]};

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int DW = 16;

  typedef struct {
    add_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  add_op_e     op;
  logic [15:0] a, b;
  logic        rdy_s1, rdy_s2, rdy_s4;
  logic        vld_s1, vld_s2, vld_s4;
  logic [16:0] sum_s1, sum_s2, sum_s4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_pipe #(.DATA_WD(DW), .STAGES(1)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_s1), .i_op(op),
    .i_a(a), .i_b(b), .o_valid(vld_s1), .i_ready(out_ready), .o_sum(sum_s1));
  adder_pipe #(.DATA_WD(DW), .STAGES(2)) u_s2 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_s2), .i_op(op),
    .i_a(a), .i_b(b), .o_valid(vld_s2), .i_ready(out_ready), .o_sum(sum_s2));
  adder_pipe #(.DATA_WD(DW), .STAGES(4)) u_s4 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_s4), .i_op(op),
    .i_a(a), .i_b(b), .o_valid(vld_s4), .i_ready(out_ready), .o_sum(sum_s4));

  logic [2:0]  ov, ordy;
  logic [16:0] os [3];
  int          lat [3] = '{1, 2, 4};
  assign ov    = {vld_s4, vld_s2, vld_s1};
  assign ordy  = {rdy_s4, rdy_s2, rdy_s1};
  assign os[0] = sum_s1;
  assign os[1] = sum_s2;
  assign os[2] = sum_s4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input add_op_e o, input logic [15:0] x, input logic [15:0] y);
    if (o == OP_SUB) return {1'b0, x} - {1'b0, y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  // ---------------- scoreboard, one queue per DUT ----------------
  logic [16:0] q0[$], q1[$], q2[$];

  task automatic sb_push(input int d, input logic [16:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int d, output logic [16:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (d)
      0: if (q0.size() == 0) ok = 1'b0; else v = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0; else v = q1.pop_front();
      default: if (q2.size() == 0) ok = 1'b0; else v = q2.pop_front();
    endcase
  endtask

  task automatic sb_clear(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int sb_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitor: inputs change just after posedge, so at negedge everything is
  // stable and reflects what the next edge will do.
  bit          rst_last = 1'b0;
  bit   [2:0]  stl_prev = '0;
  logic [16:0] os_prev [3];

  always @(negedge clk) begin
    logic [16:0] e;
    bit ok;
    for (int d = 0; d < 3; d++) begin
      if (rst_last) begin
        check($sformatf("rst_valid_s%0d", lat[d]), ov[d], 0);
        check($sformatf("rst_sum_s%0d", lat[d]), os[d], 0);
      end
      if (rst) begin
        sb_clear(d);
        stl_prev[d] = 1'b0;
      end else begin
        check($sformatf("ready_s%0d", lat[d]), ordy[d], !(ov[d] && !out_ready));
        if (stl_prev[d]) check($sformatf("hold_s%0d", lat[d]), os[d], os_prev[d]);
        if (ov[d] && out_ready) begin
          sb_pop(d, e, ok);
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL extra_s%0d got=%h want=none", lat[d], os[d]);
          end else if (os[d] !== e) begin
            failures++;
            $display("FAIL result_s%0d got=%h want=%h", lat[d], os[d], e);
          end
        end
        if (in_valid && ordy[d]) sb_push(d, model(op, a, b));
        stl_prev[d] = ov[d] && !out_ready;
        os_prev[d]  = os[d];
      end
    end
    rst_last = rst;
  end

  // One isolated op: checks exact latency and value on every DUT.
  task automatic run_vec(input add_op_e o, input logic [15:0] x, input logic [15:0] y,
                         input logic [16:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("lat_s%0d_e%0d", lat[d], e), ov[d], (e == lat[d]));
        if (e == lat[d]) check($sformatf("val_s%0d_%h", lat[d], exp), os[d], exp);
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{OP_ADD, 16'h00FF, 16'h0001, 17'h00100};
    vecs[1] = '{OP_ADD, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[2] = '{OP_SUB, 16'h0005, 16'h0003, 17'h00002};
    vecs[3] = '{OP_SUB, 16'h0000, 16'h0001, 17'h1FFFF};
    vecs[4] = '{OP_SUB, 16'h8000, 16'h8000, 17'h00000};
    vecs[5] = '{OP_ADD, 16'h8000, 16'h8000, 17'h10000};
    vecs[6] = '{OP_ADD, 16'h0F0F, 16'h00F1, 17'h01000};
    vecs[7] = '{OP_SUB, 16'h00FF, 16'hFFFF, 17'h10100};

    // Reset for two cycles with a valid beat offered; it must be ignored.
    rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 16'h1111; b = 16'h2222; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", ordy, 3'b111);
    check("no_out_after_rst", ov, 3'b000);

    foreach (vecs[i]) run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Streaming, no backpressure: every DUT must be full-throughput.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      op = add_op_e'($urandom_range(0, 1)); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      if (i >= 4) check($sformatf("stream_valid_%0d", i), ov, 3'b111);
    end

    // Backpressure: continuous valid, 50% ready.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
      op = add_op_e'($urandom_range(0, 1)); a = 16'($urandom); b = 16'($urandom);
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (sb_size(0) + sb_size(1) + sb_size(2) == 0) break;
    end
    for (int d = 0; d < 3; d++) check($sformatf("drain_s%0d", lat[d]), sb_size(d), 0);

    // Reset with two transactions in flight; neither may come out.
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_ADD; a = 16'hAAAA; b = 16'h1111;
    @(posedge clk); #1;
    op = OP_SUB; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      check($sformatf("ghost_%0d", e), ov, 3'b000);
    end
    run_vec(OP_SUB, 16'h1234, 16'h0235, 17'h00FFF);
    run_vec(OP_ADD, 16'hFFFF, 16'h0001, 17'h10000);

    repeat (2) @(posedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("final_empty_s%0d", lat[d]), sb_size(d), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Pipelined, parametrised successor to the team's combinational adder. Adds or subtracts two `DATA_WD`-bit unsigned operands through `STAGES` carry-ripple pipeline slices, with a widened `DATA_WD+1`-bit result. A valid/ready handshake on both sides lets the block sit between streaming datapath stages that apply backpressure. Throughput is one operation per cycle when not stalled; latency is `STAGES` cycles.

## Interface
- `DATA_WD`, 16: operand width; must be a multiple of `STAGES`.
- `STAGES`, 2: pipeline depth and slice count, 1..`DATA_WD`; slice width `SLICE_WD = DATA_WD/STAGES`.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_valid`  in  1: input operands valid.
- `o_ready`  out  1: block accepts an input this cycle.
- `i_op`  in  1: `add_op_e`; `OP_ADD`=0, `OP_SUB`=1.
- `i_a`  in  `DATA_WD`: operand A, unsigned.
- `i_b`  in  `DATA_WD`: operand B, unsigned.
- `o_valid`  out  1: result valid.
- `i_ready`  in  1: downstream accepts the result.
- `o_sum`  out  `DATA_WD+1`: result.

## Operation
- `OP_ADD`: `o_sum = {1'b0,a} + {1'b0,b}`. Bit `DATA_WD` is the carry-out.
- `OP_SUB`: `o_sum = ({1'b0,a} - {1'b0,b}) mod 2^(DATA_WD+1)`. This is implemented as `a + ~b + 1` with the top bit inverted.
  - Bit `DATA_WD` = 1 exactly when a < b (borrow).
  - Low `DATA_WD` bits are the wrapped difference.
- Stage k (0..`STAGES`-1) computes result slice k from:
  - operand slice k, delayed k cycles;
  - the registered carry from stage k-1.
- Stage 0 carry-in = `i_op`, with B inverted when `OP_SUB`.
- Operand slices not yet consumed, completed result slices and `i_op` travel with the data in per-stage registers.
- Each stage holds one valid bit. A transaction is captured on `i_valid && o_ready` and reaches `o_valid` `STAGES` cycles later.
- Stall rule (global): `stall = o_valid && !i_ready`.
  - While stalled, every stage register and valid bit holds.
  - `o_ready = !stall`, combinational from `o_valid` and `i_ready`.
- Bubbles are not compressed while stalled.
- An accepted transaction is never dropped or duplicated. Order is preserved.
- Result is transferred on `o_valid && i_ready`.
- `o_sum` and `o_valid` are driven from the last-stage registers only, with no combinational path from `i_a`/`i_b`.

## Timing
- Reset (synchronous, `i_rst`=1 at a rising edge):
  - all stage valid bits cleared;
  - `o_valid`=0;
  - `o_sum`=0;
  - data registers cleared to 0.
- `o_ready` = 1 in the cycle after reset, since `o_valid`=0.
- Reset mid-operation discards all in-flight transactions with no output produced.
- Inputs presented during a reset cycle are ignored.
- Latency: input accepted at edge N gives `o_valid`=1 after edge N+`STAGES`.
- `STAGES`=1 is a single registered adder with latency 1.
- Back-to-back: with `i_ready` held 1, one result per cycle, continuous.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- `i_ready` deasserted while `o_valid`=1:
  - `o_sum` holds stable;
  - `o_ready` drops the same cycle;
  - the upstream beat is not accepted.
- `i_ready` changing while `o_valid`=0 has no effect.
- Wrap-around:
  - all-ones + all-ones gives carry 1, low bits all-ones minus 1;
  - 0 − 1 gives all-ones in `DATA_WD+1` bits.

## Structure
- Package `adder_pkg` contains:
  - `typedef enum logic {OP_ADD, OP_SUB} add_op_e`;
  - a localparam helper for slice width;
  - the `DATA_WD % STAGES` legality check, used by an elaboration-time assertion in `adder_pipe`.
- Sub-module `adder_slice`:
  - combinational `SLICE_WD`-bit add;
  - ports a, b, carry-in, sum, carry-out;
  - instantiated `STAGES` times in a generate loop.
- `adder_pipe` owns all registers, valid bits and stall logic.

## Test plan
- Reset: assert `i_rst` 2 cycles with `i_valid`=1 → `o_valid`=0 and `o_sum`=0 throughout. After release, `o_ready`=1 and no spurious result appears.
- Latency and add (`DATA_WD`=16, `STAGES`=2):
  - A=0x00FF, B=0x0001 → `o_sum`=0x00100 two cycles after accept, exercising the slice carry crossing.
  - A=0xFFFF, B=0xFFFF → 0x1FFFE.
- Subtract:
  - A=0x0005, B=0x0003 → 0x00002;
  - A=0x0000, B=0x0001 → 0x1FFFF (borrow);
  - A=0x8000, B=0x8000 → 0x00000.
- Streaming: 100 random back-to-back ops with mixed `i_op` and `i_ready`=1 → one result per cycle, in order, matching the reference model.
- Backpressure: random `i_ready` (50%) with continuous `i_valid` → no loss or duplication. `o_sum` is stable while `o_valid && !i_ready`, and `o_ready` equals `!(o_valid && !i_ready)` every cycle.
- Reset mid-flight: assert `i_rst` for 1 cycle with 2 transactions in flight → neither emerges. The next accepted op produces the correct result after `STAGES` cycles. Repeat with `STAGES`=1 and `STAGES`=4.
